// File: rtl/misr_identity_core.sv
// Signature compressor: NCH channels pass through a STAGES-deep capture pipeline,
// are XOR-folded into one word and compressed into a WIDTH-bit MISR over CYCLES updates.
module misr_identity_core #(
  parameter int              WIDTH  = 8,
  parameter int              NCH    = 1,
  parameter int              STAGES = 2,
  parameter int              CYCLES = 4,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(8'h1D),
  parameter logic [WIDTH-1:0] SEED  = '0,
  localparam int             CW     = $clog2(CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NCH*WIDTH-1:0] din,
  input  logic                 din_valid,
  output logic [WIDTH-1:0]     y,
  output logic                 busy,
  output logic                 done,
  output logic [CW-1:0]        upd_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state;
  logic [NCH*WIDTH-1:0] dat_p [STAGES];
  logic [STAGES-1:0]    vld_p;
  logic                 apply;

  function automatic logic [WIDTH-1:0] fold(input logic [NCH*WIDTH-1:0] d);
    logic [WIDTH-1:0] acc;
    acc = '0;
    for (int c = 0; c < NCH; c++) acc ^= d[c*WIDTH +: WIDTH];
    return acc;
  endfunction

  function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] s,
                                                 input logic [WIDTH-1:0] f);
    return {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? POLY : '0) ^ f;
  endfunction

  // Counter never passes CYCLES, so it cannot wrap.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c >= CW'(CYCLES)) ? c : c + 1'b1;
  endfunction

  // Capture pipeline: data always shifts, valid qualifies it; start flushes in-flight words
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) dat_p[s] <= '0;
      vld_p <= '0;
    end else begin
      dat_p[0] <= din;
      vld_p[0] <= (state == RUN) && !start && din_valid;
      for (int s = 1; s < STAGES; s++) begin
        dat_p[s] <= dat_p[s-1];
        vld_p[s] <= vld_p[s-1] && !start;
      end
    end
  end

  assign apply = vld_p[STAGES-1] && (state == RUN) && (upd_cnt < CW'(CYCLES));

  // MISR and window control; start takes priority over a word leaving the pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      y       <= SEED;
      upd_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (start) begin
      state   <= RUN;
      y       <= SEED;
      upd_cnt <= '0;
      busy    <= 1'b1;
      done    <= 1'b0;
    end else if (apply) begin
      y       <= misr_step(y, fold(dat_p[STAGES-1]));
      upd_cnt <= sat_inc(upd_cnt);
      if (upd_cnt == CW'(CYCLES - 1)) begin
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_misr_identity_core.sv
// Randomized bench for misr_identity_core: a timestamped word-list reference model
// feeds a scoreboard queue that a negedge monitor drains against the DUT.
module tb_misr_identity_core;
  localparam int         WIDTH  = 8;
  localparam int         NCH    = 2;
  localparam int         STAGES = 3;
  localparam int         CYCLES = 5;
  localparam logic [7:0] POLY   = 8'h1D;
  localparam logic [7:0] SEED   = 8'hA5;
  localparam int         CW     = $clog2(CYCLES + 1);
  localparam int         NCYC   = 4000;

  logic          clk = 1'b0;
  logic          rst, start, din_valid;
  logic [15:0]   din;
  logic [7:0]    y;
  logic          busy, done;
  logic [CW-1:0] upd_cnt;

  misr_identity_core #(
    .WIDTH(WIDTH), .NCH(NCH), .STAGES(STAGES), .CYCLES(CYCLES),
    .POLY(POLY), .SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .din_valid(din_valid),
    .y(y), .busy(busy), .done(done), .upd_cnt(upd_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] w;
  } word_t;

  word_t       pend[$];
  logic [31:0] sb[$];
  int          total = 0;
  int          bad   = 0;
  int          windows_done = 0;

  logic [7:0]  m_y;
  int          m_cnt;
  bit          m_run, m_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t: got %h expected %h (y,cnt,busy,done)", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] obs();
    return {y, 8'(upd_cnt), 7'd0, busy, 7'd0, done};
  endfunction

  function automatic logic [31:0] expv();
    return {m_y, 8'(m_cnt), 7'd0, m_run, 7'd0, m_done};
  endfunction

  task automatic model_reset();
    m_y = SEED; m_cnt = 0; m_run = 0; m_done = 0;
    pend.delete();
  endtask

  // Words are stored with the edge number at which they reach the MISR.
  task automatic model_edge(input int n);
    bit          was_run, have;
    word_t       w;
    logic [7:0]  f;
    if (rst) begin
      model_reset();
      return;
    end
    was_run = m_run;
    have    = 0;
    if (pend.size() > 0 && pend[0].due == n) begin
      w = pend.pop_front();
      have = 1;
    end
    if (start) begin
      m_y = SEED; m_cnt = 0; m_run = 1; m_done = 0;
      pend.delete();
    end else if (have && was_run && m_cnt < CYCLES) begin
      f     = w.w[7:0] ^ w.w[15:8];
      m_y   = ((m_y << 1) & 8'hFF) ^ (m_y[7] ? POLY : 8'h00) ^ f;
      m_cnt = m_cnt + 1;
      if (m_cnt == CYCLES) begin
        m_run = 0; m_done = 1;
        windows_done++;
      end
    end
    if (was_run && !start && din_valid) pend.push_back('{n + STAGES, din});
  endtask

  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("cycle", obs(), e);
      end
    end
  end

  initial begin
    #(NCYC * 20);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rst_hold;
    int p;
    rst = 1'b1; start = 1'b0; din_valid = 1'b0; din = '0;
    model_reset();
    #1;
    check("reset_state", obs(), {SEED, 24'd0});
    rst_hold = 2;
    for (int n = 0; n < NCYC; n++) begin
      @(posedge clk);
      model_edge(n);
      sb.push_back(expv());
      #1;
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst = 1'b0;
      end
      p         = m_run ? 3 : (m_done ? 12 : 30);
      start     = (rst_hold == 0) && ($urandom_range(99) < p);
      din_valid = $urandom_range(99) < 65;
      din       = 16'($urandom);
      if (!rst && n > 20 && (n == 1000 || $urandom_range(999) < 4)) begin
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", obs(), {SEED, 24'd0});
        sb.delete();
        model_reset();
        sb.push_back(expv());
        rst_hold = $urandom_range(2, 1);
      end
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    check("drain", sb.size(), 0);
    check("windows_completed", 32'(windows_done > 0), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
